// File: rtl/cp_insert.sv
// rtl/cp_insert.sv - cyclic-prefix inserter: buffers one N-sample symbol, then emits its last CP_LEN samples followed by the whole symbol
module cp_insert #(
  parameter int N      = 256,
  parameter int CP_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_real,
  input  logic signed [15:0] in_imag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_real,
  output logic signed [15:0] out_imag,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_is_cp
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] CP_BASE  = AW'(N - CP_LEN);
  localparam logic [AW-1:0] CP_LAST  = AW'(CP_LEN - 1);
  localparam logic [AW-1:0] SYM_LAST = AW'(N - 1);

  typedef enum logic [1:0] {S_FILL, S_CP, S_BODY} state_t;

  state_t            state;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     rd_cnt;
  logic [AW-1:0]     cp_nxt;
  logic [AW-1:0]     body_nxt;
  logic              in_hs;
  logic              out_hs;
  logic signed [15:0] mem_re [N];
  logic signed [15:0] mem_im [N];

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign cp_nxt   = CP_BASE + rd_cnt + AW'(1);
  assign body_nxt = rd_cnt + AW'(1);

  // Sample storage carries no reset; a reset edge must not write either.
  always_ff @(posedge clk) begin
    if (rst && in_hs) begin
      mem_re[wr_cnt] <= in_real;
      mem_im[wr_cnt] <= in_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_is_cp <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_hs) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (wr_cnt == SYM_LAST) begin
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              state     <= S_CP;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sop   <= 1'b1;
              out_is_cp <= 1'b1;
              // A one-sample prefix is the sample being written right now.
              if (CP_LEN == 1) begin
                out_real <= in_real;
                out_imag <= in_imag;
              end else begin
                out_real <= mem_re[CP_BASE];
                out_imag <= mem_im[CP_BASE];
              end
            end
          end
        end
        S_CP: begin
          if (out_hs) begin
            out_sop <= 1'b0;
            if (rd_cnt == CP_LAST) begin
              rd_cnt    <= '0;
              state     <= S_BODY;
              out_is_cp <= 1'b0;
              out_eop   <= 1'b0;
              out_real  <= mem_re[0];
              out_imag  <= mem_im[0];
            end else begin
              rd_cnt   <= rd_cnt + AW'(1);
              out_real <= mem_re[cp_nxt];
              out_imag <= mem_im[cp_nxt];
            end
          end
        end
        S_BODY: begin
          if (out_hs) begin
            if (rd_cnt == SYM_LAST) begin
              rd_cnt    <= '0;
              state     <= S_FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_eop   <= 1'b0;
              out_is_cp <= 1'b0;
              out_sop   <= 1'b0;
            end else begin
              rd_cnt   <= body_nxt;
              out_real <= mem_re[body_nxt];
              out_imag <= mem_im[body_nxt];
              out_eop  <= (body_nxt == SYM_LAST);
            end
          end
        end
        default: begin
          state     <= S_FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_sop   <= 1'b0;
          out_eop   <= 1'b0;
          out_is_cp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cp_insert.md
Name: cp_insert

Overview:
- Transmit-side cyclic-prefix inserter. It is the counterpart of the receiver's delay-N autocorrelation path.
- It buffers one N-sample OFDM symbol of complex in_r_t samples.
- It then emits the last CP_LEN samples (the prefix) followed by the full N-sample symbol. The receiver's N-sample delayed correlation depends on this repetition.
- It sits between the IFFT output and the DAC/channel model.

Parameters:
- N, 256, symbol length in samples. Must be a power of 2, at least 4.
- CP_LEN, 64, prefix length. Legal range 1..N-1.
- Address and counter widths are $clog2(N).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts an input sample this cycle.
- in_real  in  in_r_t (16)  input sample, real part.
- in_imag  in  in_r_t (16)  input sample, imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts an output sample.
- out_real  out  in_r_t (16)  output sample, real part.
- out_imag  out  in_r_t (16)  output sample, imaginary part.
- out_sop  out  1  first sample of the prefixed symbol (first CP sample).
- out_eop  out  1  last sample of the prefixed symbol (body index N-1).
- out_is_cp  out  1  current output sample belongs to the prefix.

Behaviour:
- Storage:
  - Two N-entry arrays hold real and imag, 16 bits each, with no reset on the arrays.
  - Samples are stored and emitted bit-exact; there is no truncation or rounding.
- State machine has three states: FILL, CP, BODY.
- FILL:
  - in_ready=1 and out_valid=0.
  - Each accepted sample (in_valid & in_ready) is written to buf[wr_cnt], and wr_cnt increments.
  - When the sample accepted has wr_cnt==N-1:
    - wr_cnt wraps to 0.
    - State goes to CP.
    - The output register is loaded with buf-index N-CP_LEN. The write-through value is used if CP_LEN==1.
    - out_valid=1, out_sop=1 and out_is_cp=1 on the next cycle.
  - Latency is exactly 1 cycle from the last input handshake to the first out_valid.
- CP:
  - in_ready=0.
  - The output register shows buf[N-CP_LEN+rd_cnt].
  - On out_valid & out_ready, the register advances to the next index.
  - After the handshake of prefix sample CP_LEN-1, the register loads buf[0], out_is_cp drops to 0, state goes to BODY, and rd_cnt resets to 0.
- BODY:
  - in_ready=0.
  - The output register shows buf[rd_cnt]; it advances on each handshake.
  - out_eop=1 while rd_cnt==N-1.
  - The handshake on N-1 clears out_valid, out_eop and out_is_cp on the next cycle. State returns to FILL with in_ready=1 on that cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - No sample is skipped or duplicated.
- Throughput:
  - One output per cycle when out_ready is held at 1.
  - One symbol period is at minimum N input cycles + (CP_LEN+N) output cycles. There is no input/output overlap.
- in_valid while in_ready=0 is ignored; the data is not written.
- Sideband signals out_sop, out_eop and out_is_cp are meaningful only when out_valid=1. They are 0 whenever out_valid=0.
- Reset (rst=0 at a clock edge):
  - state=FILL, wr_cnt=0, rd_cnt=0, in_ready=1.
  - out_valid=0, out_real=0, out_imag=0, out_sop=0, out_eop=0, out_is_cp=0.
- Reset mid-operation:
  - Reset during FILL discards the partial symbol.
  - Reset during CP or BODY aborts emission immediately: out_valid=0 in the cycle after the reset edge.
  - After reset release, the next symbol needs N fresh inputs. Stale buffer contents are never emitted.
- Simultaneous events:
  - A reset edge overrides any handshake in the same cycle.
  - The FILL-to-CP transition and the first out_valid never coincide with the last input handshake cycle; they occur one cycle after it.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with random inputs -> in_ready=1, out_valid=0, and all out_* equal to 0 throughout.
- Ramp symbol: feed in_real=k and in_imag=-k for k=0..255 with out_ready=1 (defaults).
  - Required output: exactly 320 valid samples on consecutive cycles, starting 1 cycle after the last input.
  - Samples 0..63 carry real=192..255 with out_is_cp=1, and out_sop=1 only on the first.
  - Samples 64..319 carry real=0..255 with out_is_cp=0, and out_eop=1 only on the last.
  - in_ready=0 for all 320 cycles.
- Backpressure: same ramp with out_ready driven by a random 50% pattern -> sequence identical to the ramp test, and out_* stable on every cycle where out_ready=0.
- Input gaps and ignored writes:
  - in_valid toggling during FILL -> the symbol is still assembled in order.
  - in_valid=1 with distinct data during CP/BODY -> that data never appears in the output.
  - The next symbol accepted after out_eop is emitted correctly.
- Back-to-back symbols: second symbol with real=1000+k -> its prefix starts with 1192, and out_sop is asserted again.
- Reset mid-CP: assert rst=0 at prefix sample 10 -> out_valid=0 the next cycle. After release, a new ramp 500+k produces a prefix starting at 692 and contains no values from the old symbol.
